// File: rtl/barret_2689_pkg.sv
// Shared constants and FSM state type for the mod-2689 reducer arbiter.
// Q is the modulus; QSQ = Q*Q bounds the operand range of exact reduction.
package barret_2689_pkg;

  localparam int Q  = 2689;
  localparam int QW = 12;
  localparam int DW = 23;

  localparam logic [DW-1:0] QSQ = 23'd7230721;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    RESP
  } state_e;

endpackage

// File: rtl/barret_2689_arbiter_rr.sv
// Round-robin grant: first set req bit searching upward from last+1.
// Ports: req, last -> one-hot gnt, gnt_id, gnt_any.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last) + off) % NREQ;
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/barret_for_2689.sv
// Combinational Barrett reduction of a 23-bit operand modulo 2689.
// Ports: din (DW operand) -> dout (QW result, 0..2688).
module barret_for_2689
  import barret_2689_pkg::*;
(
  input  logic [DW-1:0] din,
  output logic [QW-1:0] dout
);

  // m = floor(2^24 / 2689); the quotient estimate is low by at
  // most 2, so two conditional subtractions finish the job.
  localparam logic [35:0] M  = 36'd6239;
  localparam int          K  = 24;
  localparam int          RW = DW + 1;
  localparam logic [RW-1:0] QR = RW'(Q);

  logic [QW-1:0] qe;
  logic [RW-1:0] r0;
  logic [RW-1:0] r1;
  logic [RW-1:0] r2;

  assign qe = QW'(({13'd0, din} * M) >> K);
  assign r0 = {1'b0, din} - RW'({12'd0, qe} * QR);
  assign r1 = (r0 >= QR) ? r0 - QR : r0;
  assign r2 = (r1 >= QR) ? r1 - QR : r1;
  assign dout = QW'(r2);

endmodule

// File: rtl/barret_2689_arbiter.sv
// Shares one barret_for_2689 reducer among NREQ valid/ready requesters.
// Ports: req_valid/req_data/req_ready in, rsp_* out, done_count.
// Optional: BARRET_2689_RANGE_CHECK_EN flags operands >= 2689*2689.
module barret_2689_arbiter
  import barret_2689_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [QW-1:0]        rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  input  logic                 rsp_ready,
  output logic [CNTW-1:0]      done_count
);

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [DW-1:0]   op_q, op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [QW-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [CNTW-1:0] done_q, done_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic [DW-1:0]   op_sel;
  logic [QW-1:0]   red;
  logic [QW-1:0]   red_eff;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (req_valid),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  barret_for_2689 u_red (
    .din  (op_q),
    .dout (red)
  );

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) op_sel = req_data[i*DW +: DW];
    end
  end

`ifdef BARRET_2689_RANGE_CHECK_EN
  logic err_q, err_d;
  logic rsp_err_q, rsp_err_d;

  always_comb begin
    err_d     = err_q;
    rsp_err_d = rsp_err_q;
    if (state_q == IDLE && gnt_any) err_d = (op_sel >= QSQ);
    if (state_q == REDUCE) rsp_err_d = err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign red_eff = err_q ? '0 : red;
  assign rsp_err = rsp_err_q;
`else
  assign red_eff = red;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    done_d      = done_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        // Gate with rst so the grant strobe is quiet during reset.
        if (!rst) req_ready = gnt;
        if (gnt_any) begin
          op_d    = op_sel;
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = REDUCE;
        end
      end
      REDUCE: begin
        rsp_data_d  = red_eff;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_d      = done_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      done_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      done_q      <= done_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign done_count = done_q;

endmodule

// File: tb/tb_barret_2689_arbiter.sv
// Scoreboard bench for barret_2689_arbiter: directed vectors, queued
// expectations, response monitor decoupled from stimulus.
module tb_barret_2689_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [91:0]   req_data;
  logic [3:0]    req_ready;
  logic          rsp_valid;
  logic [11:0]   rsp_data;
  logic [1:0]    rsp_id;
  logic          rsp_err;
  logic          rsp_ready;
  logic [15:0]   done_count;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   applied = 0;
  int   miscompares = 0;

  barret_2689_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_data), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic wait_grant(int id);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[id] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[id]) chk("grant_timeout", 32'(id), 32'hFF);
  endtask

  task automatic issue(int id, logic [22:0] op, logic [11:0] d, logic e);
    sb.push_back('{id: 2'(id), data: d, err: e});
    req_data[23*id +: 23] = op;
    req_valid[id] = 1'b1;
    wait_grant(id);
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic [22:0] op;
    logic [11:0] d;
    logic        e;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 23'd0,       12'd0,    1'b0};
    vecs[1] = '{1, 23'd2688,    12'd2688, 1'b0};
    vecs[2] = '{2, 23'd2689,    12'd0,    1'b0};
    vecs[3] = '{0, 23'd7230720, 12'd2688, 1'b0};
`ifdef BARRET_2689_RANGE_CHECK_EN
    vecs[4] = '{1, 23'd7230721, 12'd0,    1'b1};
    vecs[5] = '{3, 23'd8388607, 12'd0,    1'b1};
`else
    vecs[4] = '{1, 23'd7230721, 12'd0,    1'b0};
    vecs[5] = '{3, 23'd8388607, 12'd1616, 1'b0};
`endif

    rst = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_done", 32'(done_count), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    req_valid = 4'b0000;
    @(posedge clk);
    #1 rst = 1'b0;

    // single request with latency check
    sb.push_back('{id: 2'd0, data: 12'd2311, err: 1'b0});
    req_data[22:0] = 23'd5000;
    req_valid[0] = 1'b1;
    wait_grant(0);
    chk("single_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("lat_edge1", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("lat_edge2", 32'(rsp_valid), 1);
    drain();
    chk("done_single", 32'(done_count), 1);

    // boundaries
    foreach (vecs[i]) begin
      issue(vecs[i].id, vecs[i].op, vecs[i].d, vecs[i].e);
      drain();
    end
    chk("done_bound", 32'(done_count), 7);

    // round robin, last grant went to requester 3
    for (int i = 0; i < 4; i++) begin
      req_data[23*i +: 23] = 23'(100 + i);
    end
    for (int g = 0; g < 5; g++) begin
      sb.push_back('{id: 2'(g % 4), data: 12'(100 + g % 4), err: 1'b0});
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready == 4'b0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
      @(posedge clk);
    end
    #1 req_valid = 4'b0000;
    drain();
    chk("done_rr", 32'(done_count), 12);

    // backpressure
    rsp_ready = 1'b0;
    issue(2, 23'd5000, 12'd2311, 1'b0);
    req_data[22:0] = 23'd0;
    req_data[45:23] = 23'd200;
    req_valid[1] = 1'b1;
    begin
      int n;
      n = 0;
      while (!rsp_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 2311);
      chk("bp_id", 32'(rsp_id), 2);
      chk("bp_req_ready", 32'(req_ready), 0);
      chk("bp_done", 32'(done_count), 12);
      @(negedge clk);
    end
    sb.push_back('{id: 2'd1, data: 12'd200, err: 1'b0});
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant(1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    drain();
    chk("done_bp", 32'(done_count), 14);

    // reset while in REDUCE; requester 2 was last before reset
    req_data[68:46] = 23'd999;
    req_valid[2] = 1'b1;
    wait_grant(2);
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", 32'(rsp_valid), 0);
    chk("rstmid_done", 32'(done_count), 0);
    req_data[22:0] = 23'd500;
    req_data[91:69] = 23'd600;
    req_valid = 4'b1001;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.push_back('{id: 2'd0, data: 12'd500, err: 1'b0});
    @(negedge clk);
    chk("rstmid_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 4'b0000;
    drain();
    chk("done_after_rst", 32'(done_count), 1);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
